// File: rtl/burst_read_sequencer_if.sv
// Command and read-master control bundle for the burst read sequencer.
interface burst_read_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter int unsigned LENGTH_WIDTH     = 24,
  parameter int unsigned BURST_WIDTH      = 4,
  parameter int unsigned FIFO_USEDW_WIDTH = 10
);
  logic                        cmd_start;
  logic [ADDRESS_WIDTH-1:0]    cmd_baseaddress;
  logic [LENGTH_WIDTH-1:0]     cmd_length;
  logic                        cmd_busy;
  logic                        cmd_done;
  logic                        cmd_error;
  logic                        rd_start;
  logic [ADDRESS_WIDTH-1:0]    rd_baseaddress;
  logic [BURST_WIDTH-1:0]      rd_burstcount;
  logic                        rd_busy;
  logic                        rd_readdatavalid;
  logic [FIFO_USEDW_WIDTH-1:0] fifo_usedw;

  // Sequencer side
  modport slave (
    input  cmd_start, cmd_baseaddress, cmd_length,
    input  rd_busy, rd_readdatavalid, fifo_usedw,
    output cmd_busy, cmd_done, cmd_error,
    output rd_start, rd_baseaddress, rd_burstcount
  );

  // Controller / read-master side
  modport master (
    output cmd_start, cmd_baseaddress, cmd_length,
    output rd_busy, rd_readdatavalid, fifo_usedw,
    input  cmd_busy, cmd_done, cmd_error,
    input  rd_start, rd_baseaddress, rd_burstcount
  );
endinterface

// File: rtl/burst_read_sequencer.sv
// Splits a long linear read into bursts of at most BURST_COUNT words,
// issuing each burst only when the downstream FIFO can absorb all its beats.
module burst_read_sequencer #(
  parameter int unsigned ADDRESS_WIDTH       = 32,
  parameter int unsigned LENGTH_WIDTH        = 24,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned BYTES_PER_WORD_LOG2 = 2,
  parameter int unsigned BURST_COUNT         = 8,
  parameter int unsigned BURST_WIDTH         = 4,
  parameter int unsigned FIFO_DEPTH          = 512,
  parameter int unsigned FIFO_USEDW_WIDTH    = 10
) (
  input logic                    clk,
  input logic                    reset,
  burst_read_sequencer_if.slave  bus
);

  // Parameter consistency guards
  if (DATA_WIDTH != (8 << BYTES_PER_WORD_LOG2)) begin : g_bad_word_size
    $error("DATA_WIDTH does not match BYTES_PER_WORD_LOG2");
  end
  if (BURST_COUNT >= (1 << BURST_WIDTH)) begin : g_bad_burst_width
    $error("BURST_WIDTH cannot hold BURST_COUNT");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [LENGTH_WIDTH-1:0]  remaining;
  logic [BURST_WIDTH-1:0]   cur;
  logic [BURST_WIDTH-1:0]   beats;

  logic [BURST_WIDTH-1:0]   cur_next_c;
  logic                     room_c;
  logic                     in_burst_c;

  // Next burst size and whether the FIFO has space for every beat of it
  always_comb begin
    cur_next_c = BURST_WIDTH'(BURST_COUNT);
    if (remaining < LENGTH_WIDTH'(BURST_COUNT)) begin
      cur_next_c = BURST_WIDTH'(remaining);
    end
    room_c     = (32'(bus.fifo_usedw) + 32'(cur_next_c)) <= 32'(FIFO_DEPTH);
    in_burst_c = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);
  end

  // Sequencer state machine with registered outputs and beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      addr               <= '0;
      remaining          <= '0;
      cur                <= '0;
      beats              <= '0;
      bus.cmd_busy       <= 1'b0;
      bus.cmd_done       <= 1'b0;
      bus.cmd_error      <= 1'b0;
      bus.rd_start       <= 1'b0;
      bus.rd_baseaddress <= '0;
      bus.rd_burstcount  <= '0;
    end else begin
      // Beats only matter while a burst is outstanding; an extra beat saturates
      if (in_burst_c && bus.rd_readdatavalid) begin
        if (beats == cur) begin
          bus.cmd_error <= 1'b1;
        end else begin
          beats <= beats + BURST_WIDTH'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.cmd_start) begin
            addr          <= bus.cmd_baseaddress;
            remaining     <= bus.cmd_length;
            bus.cmd_error <= 1'b0;
            bus.cmd_busy  <= 1'b1;
            state         <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (remaining == '0) begin
            bus.cmd_done <= 1'b1;
            state        <= S_DONE;
          end else if (room_c) begin
            bus.rd_start       <= 1'b1;
            bus.rd_baseaddress <= addr;
            bus.rd_burstcount  <= cur_next_c;
            cur                <= cur_next_c;
            beats              <= '0;
            state              <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          bus.rd_start <= 1'b0;
          if (bus.rd_busy) begin
            state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (!bus.rd_busy) begin
            if (beats == cur) begin
              addr      <= addr + (ADDRESS_WIDTH'(cur) << BYTES_PER_WORD_LOG2);
              remaining <= remaining - LENGTH_WIDTH'(cur);
              state     <= S_CHECK;
            end else begin
              bus.cmd_error <= 1'b1;
              bus.cmd_done  <= 1'b1;
              state         <= S_DONE;
            end
          end
        end

        S_DONE: begin
          bus.cmd_done <= 1'b0;
          bus.cmd_busy <= 1'b0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/burst_read_sequencer.md
Name: burst_read_sequencer

Overview:
Sequences a long linear read of cmd_length words into a chain of bursts, each at most BURST_COUNT words, on the burst read master's control interface (start/baseaddress/burstcount/busy). Each burst is issued only when the downstream read-data FIFO has room for all of its beats. One burst is outstanding at a time; beats are counted to confirm each burst completes. Sits between the frame/DMA control logic and the Avalon burst read master.

Parameters:
ADDRESS_WIDTH, 32, byte address width of master and command
LENGTH_WIDTH, 24, width of transfer length in words
DATA_WIDTH, 32, data word width; bytes per word = DATA_WIDTH/8
BYTES_PER_WORD_LOG2, 2, log2(DATA_WIDTH/8)
BURST_COUNT, 8, maximum words per burst (power of 2, 1..1024)
BURST_WIDTH, 4, width of burstcount; must hold BURST_COUNT
FIFO_DEPTH, 512, downstream FIFO capacity in words
FIFO_USEDW_WIDTH, 10, width of fifo_usedw

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_start  in  1  start request, sampled only in IDLE
cmd_baseaddress  in  ADDRESS_WIDTH  first byte address, latched on accept
cmd_length  in  LENGTH_WIDTH  total words, latched on accept
cmd_busy  out  1  transfer in progress
cmd_done  out  1  one-cycle pulse at end of transfer
cmd_error  out  1  sticky protocol error for last transfer
rd_start  out  1  one-cycle burst request to read master
rd_baseaddress  out  ADDRESS_WIDTH  burst byte address
rd_burstcount  out  BURST_WIDTH  burst length in words
rd_busy  in  1  read master busy
rd_readdatavalid  in  1  read beat returned
fifo_usedw  in  FIFO_USEDW_WIDTH  downstream FIFO fill level

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; addr, remaining, cur, and beat counters 0. Reset mid-burst abandons it with no done pulse.
- IDLE: cmd_start=1 latches addr=cmd_baseaddress, remaining=cmd_length, clears cmd_error, sets cmd_busy=1, and goes to CHECK. cmd_start is ignored in every other state.
- CHECK: cur = min(remaining, BURST_COUNT).
  - remaining==0 -> DONE.
  - Else if (FIFO_DEPTH - fifo_usedw) >= cur: register rd_start=1, rd_baseaddress=addr, rd_burstcount=cur, beats=0, and go to WAIT_ACK.
  - Else stay in CHECK and re-evaluate every cycle.
- WAIT_ACK: rd_start=0 (exactly one cycle high). rd_busy=1 -> WAIT_DONE.
- WAIT_DONE: rd_busy=0 -> end of burst.
  - If beats==cur: addr += cur<<BYTES_PER_WORD_LOG2 (modulo 2^ADDRESS_WIDTH, wrap allowed); remaining -= cur; go to CHECK.
  - If beats!=cur: cmd_error=1 -> DONE.
- Beat counting: rd_readdatavalid increments beats in WAIT_ACK and WAIT_DONE. A beat arriving when beats==cur sets cmd_error=1; the count saturates. Beats in IDLE/CHECK/DONE are ignored.
- rd_baseaddress and rd_burstcount hold stable from the rd_start cycle until the next issue.
- DONE: cmd_done=1 for one cycle, cmd_busy=0 on the following cycle, then -> IDLE. cmd_error holds until the next accepted cmd_start.
- Latency:
  - cmd_start sampled at edge N -> CHECK in cycle N+1; earliest rd_start is high in cycle N+2.
  - Burst end (rd_busy low in WAIT_DONE) -> next rd_start at the earliest 2 cycles later.
  - cmd_length=0 -> cmd_done in cycle N+2.
- Last burst is shorter when cmd_length is not a multiple of BURST_COUNT.
- Total rd_start pulses = ceil(cmd_length/BURST_COUNT).

Test Plan:
- base=0x39000000, length=20, fifo_usedw=0, reader model returns burstcount beats -> three rd_start pulses: (0x39000000,8), (0x39000020,8), (0x39000040,4); 20 beats; one cmd_done; cmd_error=0.
- length=0 -> no rd_start; cmd_done high 2 cycles after cmd_start; cmd_busy high exactly 2 cycles.
- length=8, fifo_usedw=508 -> stays in CHECK with no rd_start; drop usedw to 504 -> rd_start next edge with burstcount 8.
- Reader drops rd_busy after 5 of 8 beats -> cmd_error=1, cmd_done pulse, no further rd_start; next cmd_start clears cmd_error.
- cmd_start pulsed again mid-transfer (length=16) -> ignored: still exactly 2 bursts, one cmd_done.
- Reset asserted during WAIT_DONE of burst 2 -> all outputs 0 immediately. After release, a new cmd_start (base=0x100, length=4) -> single burst (0x100,4) and completes normally.
